emu_bus_bridge: RTL and testbench
=================================

Name: emu_bus_bridge

Overview:
Parametrised FPGA-emulator I/O bridge between the Pmod bus pins and the design-under-test (DUT) top level. It resynchronises inbound data and control, and retimes the outbound hash and control signals. It sequences the DUT reset from PLL lock with a programmable hold-off, and adds loopback and pattern-generator bus test modes. It also counts DUT error pulses for the debug LEDs.

Parameters:
DATA_W, 8, width of inbound data bus and outbound hash bus
CTRL_IN_W, 3, width of inbound data-control bus (must be >= 2)
CTRL_OUT_W, 2, width of outbound hash-control bus (must be <= CTRL_IN_W)
SYNC_STAGES, 2, inbound synchroniser depth (>= 2)
OUT_STAGES, 2, outbound retiming depth (>= 1)
RST_HOLD, 16, cycles the bridge waits after synced PLL lock before releasing DUT reset (>= 1)
ERR_CNT_W, 8, error counter width

Ports:
clk  in  1  bridge/DUT clock (PLL output after BUFG)
rst_async  in  1  asynchronous active-high reset
pll_lock_i  in  1  PLL LOCKED, asynchronous
data_i  in  DATA_W  inbound bus data (post-IBUF)
data_ctrl_i  in  CTRL_IN_W  inbound bus control
loopback_ctrl_i  in  2  test-mode select, asynchronous
hash_o  out  DATA_W  outbound bus data (to OBUF)
hash_ctrl_o  out  CTRL_OUT_W  outbound bus control
dut_data_o  out  DATA_W  synced data to DUT
dut_ctrl_o  out  CTRL_IN_W  synced control to DUT
dut_rst_n_o  out  1  DUT active-low reset, registered
dut_hash_i  in  DATA_W  DUT hash output
dut_hash_ctrl_i  in  CTRL_OUT_W  DUT hash control (e.g. {hash_v, ready})
err_i  in  1  DUT error flag
err_cnt_o  out  ERR_CNT_W  saturating error count
status_o  out  8  {mode[1:0], err_sticky, rst_state[1:0], lock_sync, dut_rst_n_o, 1'b0}

Behaviour:
- Reset (rst_async=1): all sync/retime flops 0. Outputs during reset: hash_o=0, hash_ctrl_o=0, dut_data_o=0, dut_ctrl_o=0, dut_rst_n_o=0, err_cnt_o=0, state=WAIT_LOCK, pattern counter=0.
- Inbound path: data_i, data_ctrl_i and loopback_ctrl_i each pass through SYNC_STAGES flops.
  - dut_data_o and dut_ctrl_o are the last stage; latency is SYNC_STAGES cycles.
  - mode is the last stage of the loopback_ctrl sync chain.
- Outbound mux, combinational, selected by mode:
  - 00 normal: {dut_hash_i, dut_hash_ctrl_i}
  - 01 loopback: {dut_data_o, dut_ctrl_o[CTRL_OUT_W-1:0]}
  - 10 pattern: {pat_cnt, CTRL_OUT_W'(all ones)}
  - 11 fixed: {DATA_W'(alternating 1010…0101, i.e. 0xA5 for DATA_W=8), CTRL_OUT_W'(0)}
- The mux output passes through OUT_STAGES flops to hash_o/hash_ctrl_o. End-to-end loopback latency is SYNC_STAGES+OUT_STAGES cycles.
- pat_cnt (DATA_W bits):
  - held at 0 while mode!=10;
  - increments by 1 each cycle while mode==10;
  - wraps from all-ones to 0.
  - The first pattern value presented is 0.
- Mode change takes effect on the mux in the cycle the synced mode changes. No glitch filtering is applied.
- PLL lock: pll_lock_i is synced through 2 fixed flops to give lock_sync.
- Reset sequencer FSM, rst_state encoding WAIT_LOCK=00, HOLD=01, RUN=10:
  - WAIT_LOCK: if lock_sync goes to HOLD, hold_cnt=0.
  - HOLD: hold_cnt increments; when hold_cnt==RST_HOLD-1 goes to RUN.
  - RUN: stays while lock_sync=1.
  - Any state with lock_sync=0 goes to WAIT_LOCK. This has priority over the HOLD count completing.
- dut_rst_n_o is registered, =1 iff next state is RUN. It rises exactly 3+RST_HOLD edges after pll_lock_i is first sampled high, and falls 3 edges after pll_lock_i is first sampled low.
- Error counter:
  - increments each cycle err_i=1 AND dut_rst_n_o=1;
  - saturates at all-ones;
  - cleared only by rst_async, so it is preserved across PLL relock.
  - err_sticky = (err_cnt_o != 0).
- rst_async asserted mid-operation forces the reset values asynchronously. Recovery follows the full sequencer path.

Test Plan:
- Reset release with pll_lock_i=1 already high: dut_rst_n_o=0 for 18 edges, =1 after edge 19; status_o rst_state sequences 00→01→10.
- Lock drop in RUN (pll_lock_i low 1 cycle after rst_n high): dut_rst_n_o=0 3 edges later. Lock drop at hold_cnt=15 wins, state→WAIT_LOCK, no release.
- Mode 00: dut_hash_i=0x3C, dut_hash_ctrl_i=2'b10 → hash_o=0x3C, hash_ctrl_o=2'b10 after 2 cycles. Mode 01: data_i=0x5A, data_ctrl_i=3'b101 → hash_o=0x5A, hash_ctrl_o=2'b01 after 4 cycles.
- Mode 10 for 300 cycles: hash_o steps 0,1,…,0xFF,0,… with hash_ctrl_o=2'b11. Leave and re-enter mode 10: sequence restarts at 0.
- Mode 11: hash_o=0xA5, hash_ctrl_o=2'b00 stable.
- Error counting: err_i high 5 cycles while dut_rst_n_o=0 → err_cnt_o=0. Then high 300 cycles in RUN → err_cnt_o saturates at 0xFF, err_sticky=1. Lock loss/relock → err_cnt_o stays 0xFF. rst_async → 0.

Source files
------------

// File: rtl/emu_bus_bridge.sv
// Emulator I/O bridge between the Pmod bus pins and the DUT top level: inbound resync,
// outbound retiming with bus test modes, PLL-lock-driven DUT reset sequencing and error counting.
module emu_bus_bridge #(
    parameter int DATA_W      = 8,
    parameter int CTRL_IN_W   = 3,
    parameter int CTRL_OUT_W  = 2,
    parameter int SYNC_STAGES = 2,
    parameter int OUT_STAGES  = 2,
    parameter int RST_HOLD    = 16,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst_async,
    input  logic                  pll_lock_i,
    input  logic [DATA_W-1:0]     data_i,
    input  logic [CTRL_IN_W-1:0]  data_ctrl_i,
    input  logic [1:0]            loopback_ctrl_i,
    output logic [DATA_W-1:0]     hash_o,
    output logic [CTRL_OUT_W-1:0] hash_ctrl_o,
    output logic [DATA_W-1:0]     dut_data_o,
    output logic [CTRL_IN_W-1:0]  dut_ctrl_o,
    output logic                  dut_rst_n_o,
    input  logic [DATA_W-1:0]     dut_hash_i,
    input  logic [CTRL_OUT_W-1:0] dut_hash_ctrl_i,
    input  logic                  err_i,
    output logic [ERR_CNT_W-1:0]  err_cnt_o,
    output logic [7:0]            status_o
);

    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam int OUT_W  = DATA_W + CTRL_OUT_W;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'b00,
        HOLD      = 2'b01,
        RUN       = 2'b10
    } rst_state_e;

    typedef enum logic [1:0] {
        MODE_NORMAL   = 2'b00,
        MODE_LOOPBACK = 2'b01,
        MODE_PATTERN  = 2'b10,
        MODE_FIXED    = 2'b11
    } bus_mode_e;

    // Upper half reads 1010..., lower half 0101... (0xA5 at 8 bits).
    function automatic logic [DATA_W-1:0] fixed_pattern();
        logic [DATA_W-1:0] v;
        v = '0;
        for (int i = 0; i < DATA_W; i++)
            v[i] = (i >= DATA_W / 2) ? (i % 2 == 1) : (i % 2 == 0);
        return v;
    endfunction

    localparam logic [DATA_W-1:0] FIXED_PAT = fixed_pattern();

    logic [SYNC_STAGES-1:0][DATA_W-1:0]    r_data_sync;
    logic [SYNC_STAGES-1:0][CTRL_IN_W-1:0] r_ctrl_sync;
    logic [SYNC_STAGES-1:0][1:0]           r_mode_sync;
    logic [1:0]                            r_lock_sync;
    logic [OUT_STAGES-1:0][OUT_W-1:0]      r_out;
    logic [DATA_W-1:0]                     r_pat_cnt;
    logic [ERR_CNT_W-1:0]                  r_err_cnt;
    logic [HOLD_W-1:0]                     r_hold_cnt;
    logic                                  r_dut_rst_n;
    rst_state_e                            r_state;

    bus_mode_e         w_mode;
    logic              w_lock_sync;
    logic [OUT_W-1:0]  w_mux;
    rst_state_e        w_state_next;
    logic [HOLD_W-1:0] w_hold_next;

    // NOTE: all state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            r_data_sync <= '0;
            r_ctrl_sync <= '0;
            r_mode_sync <= '0;
            r_lock_sync <= '0;
        end else begin
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], data_i};
            r_ctrl_sync <= {r_ctrl_sync[SYNC_STAGES-2:0], data_ctrl_i};
            r_mode_sync <= {r_mode_sync[SYNC_STAGES-2:0], loopback_ctrl_i};
            r_lock_sync <= {r_lock_sync[0], pll_lock_i};
        end
    end

    assign w_mode      = bus_mode_e'(r_mode_sync[SYNC_STAGES-1]);
    assign w_lock_sync = r_lock_sync[1];
    assign dut_data_o  = r_data_sync[SYNC_STAGES-1];
    assign dut_ctrl_o  = r_ctrl_sync[SYNC_STAGES-1];

    // NOTE: default assigned first so no path through the case leaves w_mux unassigned (no latch).
    always_comb begin
        w_mux = '0;
        case (w_mode)
            MODE_NORMAL:   w_mux = {dut_hash_i, dut_hash_ctrl_i};
            MODE_LOOPBACK: w_mux = {dut_data_o, dut_ctrl_o[CTRL_OUT_W-1:0]};
            MODE_PATTERN:  w_mux = {r_pat_cnt, {CTRL_OUT_W{1'b1}}};
            MODE_FIXED:    w_mux = {FIXED_PAT, {CTRL_OUT_W{1'b0}}};
            default:       w_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            r_out     <= '0;
            r_pat_cnt <= '0;
        end else begin
            r_out[0] <= w_mux;
            for (int i = 1; i < OUT_STAGES; i++)
                r_out[i] <= r_out[i-1];
            r_pat_cnt <= (w_mode == MODE_PATTERN) ? r_pat_cnt + DATA_W'(1) : '0;
        end
    end

    assign {hash_o, hash_ctrl_o} = r_out[OUT_STAGES-1];

    // Losing lock beats a completing hold count.
    always_comb begin
        w_state_next = r_state;
        w_hold_next  = r_hold_cnt;
        case (r_state)
            WAIT_LOCK: begin
                w_hold_next = '0;
                if (w_lock_sync) w_state_next = HOLD;
            end
            HOLD: begin
                if (!w_lock_sync) begin
                    w_state_next = WAIT_LOCK;
                    w_hold_next  = '0;
                end else if (r_hold_cnt == HOLD_W'(RST_HOLD - 1)) begin
                    w_state_next = RUN;
                end else begin
                    w_hold_next = r_hold_cnt + HOLD_W'(1);
                end
            end
            RUN: begin
                if (!w_lock_sync) w_state_next = WAIT_LOCK;
            end
            default: begin
                w_state_next = WAIT_LOCK;
                w_hold_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            r_state     <= WAIT_LOCK;
            r_hold_cnt  <= '0;
            r_dut_rst_n <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_hold_cnt  <= w_hold_next;
            r_dut_rst_n <= (w_state_next == RUN);
        end
    end

    // Only rst_async clears the count, so it survives a PLL relock.
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async)
            r_err_cnt <= '0;
        else if (err_i && r_dut_rst_n && !(&r_err_cnt))
            r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
    end

    assign dut_rst_n_o = r_dut_rst_n;
    assign err_cnt_o   = r_err_cnt;
    assign status_o    = {w_mode, |r_err_cnt, r_state, w_lock_sync, r_dut_rst_n, 1'b0};

endmodule

// File: tb/tb_emu_bus_bridge.sv
// Scoreboard bench for emu_bus_bridge: stimulus queues cycle-tagged expectations,
// a monitor process compares them against DUT outputs one delta after each rising edge.
module tb_emu_bus_bridge;

    localparam int DATA_W     = 8;
    localparam int CTRL_IN_W  = 3;
    localparam int CTRL_OUT_W = 2;
    localparam int ERR_CNT_W  = 8;

    logic                  clk = 1'b0;
    logic                  rst_async;
    logic                  pll_lock_i;
    logic [DATA_W-1:0]     data_i;
    logic [CTRL_IN_W-1:0]  data_ctrl_i;
    logic [1:0]            loopback_ctrl_i;
    logic [DATA_W-1:0]     hash_o;
    logic [CTRL_OUT_W-1:0] hash_ctrl_o;
    logic [DATA_W-1:0]     dut_data_o;
    logic [CTRL_IN_W-1:0]  dut_ctrl_o;
    logic                  dut_rst_n_o;
    logic [DATA_W-1:0]     dut_hash_i;
    logic [CTRL_OUT_W-1:0] dut_hash_ctrl_i;
    logic                  err_i;
    logic [ERR_CNT_W-1:0]  err_cnt_o;
    logic [7:0]            status_o;

    emu_bus_bridge dut (
        .clk             (clk),
        .rst_async       (rst_async),
        .pll_lock_i      (pll_lock_i),
        .data_i          (data_i),
        .data_ctrl_i     (data_ctrl_i),
        .loopback_ctrl_i (loopback_ctrl_i),
        .hash_o          (hash_o),
        .hash_ctrl_o     (hash_ctrl_o),
        .dut_data_o      (dut_data_o),
        .dut_ctrl_o      (dut_ctrl_o),
        .dut_rst_n_o     (dut_rst_n_o),
        .dut_hash_i      (dut_hash_i),
        .dut_hash_ctrl_i (dut_hash_ctrl_i),
        .err_i           (err_i),
        .err_cnt_o       (err_cnt_o),
        .status_o        (status_o)
    );

    typedef enum {K_HASH, K_RSTN, K_ERR, K_STATE, K_STICKY, K_STATUS, K_DATA, K_DCTRL, K_MODE} kind_e;

    typedef struct {
        int          cyc;
        kind_e       kind;
        string       name;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   mon_i;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] sample(input kind_e k);
        case (k)
            K_HASH:   return 32'({hash_o, hash_ctrl_o});
            K_RSTN:   return 32'(dut_rst_n_o);
            K_ERR:    return 32'(err_cnt_o);
            K_STATE:  return 32'(status_o[4:3]);
            K_STICKY: return 32'(status_o[5]);
            K_STATUS: return 32'(status_o);
            K_DATA:   return 32'(dut_data_o);
            K_DCTRL:  return 32'(dut_ctrl_o);
            K_MODE:   return 32'(status_o[7:6]);
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Expect value v on output kind k after d more rising edges (d >= 1).
    task automatic exp_at(input kind_e k, input string nm, input logic [31:0] v, input int d);
        exp_t e;
        e.cyc  = cyc + d;
        e.kind = k;
        e.name = nm;
        e.exp  = v;
        sb_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    always begin
        @(posedge clk);
        #1;
        mon_i = 0;
        while (mon_i < sb_q.size()) begin
            if (sb_q[mon_i].cyc == cyc) begin
                check(sb_q[mon_i].name, sample(sb_q[mon_i].kind), sb_q[mon_i].exp);
                sb_q.delete(mon_i);
            end else if (sb_q[mon_i].cyc < cyc) begin
                n_checks++;
                n_errors++;
                $display("FAIL %s: expectation for cycle %0d never compared", sb_q[mon_i].name, sb_q[mon_i].cyc);
                sb_q.delete(mon_i);
            end else begin
                mon_i++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_async       = 1'b1;
        pll_lock_i      = 1'b1;
        data_i          = 8'hFF;
        data_ctrl_i     = 3'b111;
        loopback_ctrl_i = 2'b11;
        dut_hash_i      = 8'h00;
        dut_hash_ctrl_i = 2'b00;
        err_i           = 1'b1;

        // Reset holds every output at zero even with busy inputs.
        tick(3);
        exp_at(K_STATUS, "rst_status", 32'h00, 1);
        exp_at(K_HASH,   "rst_hash",   32'h000, 1);
        exp_at(K_RSTN,   "rst_rstn",   32'h0, 1);
        exp_at(K_ERR,    "rst_err",    32'h00, 1);
        exp_at(K_DATA,   "rst_data",   32'h00, 1);
        exp_at(K_DCTRL,  "rst_dctrl",  32'h0, 1);
        tick(2);

        // Release with lock already high: DUT reset lifts on edge 19; errors ignored while held.
        rst_async       = 1'b0;
        loopback_ctrl_i = 2'b00;
        data_i          = 8'h00;
        data_ctrl_i     = 3'b000;
        exp_at(K_STATE,  "seq_wait",     32'h0, 2);
        exp_at(K_STATE,  "seq_hold",     32'h1, 3);
        exp_at(K_STATE,  "seq_hold_e18", 32'h1, 18);
        exp_at(K_RSTN,   "seq_rstn_e18", 32'h0, 18);
        exp_at(K_RSTN,   "seq_rstn_e19", 32'h1, 19);
        exp_at(K_STATE,  "seq_run",      32'h2, 19);
        exp_at(K_STATUS, "seq_status",   32'h16, 19);
        exp_at(K_ERR,    "err_in_reset", 32'h00, 6);
        exp_at(K_ERR,    "err_at_run",   32'h00, 19);
        tick(5);
        err_i = 1'b0;
        tick(20);

        // Normal mode: two-cycle outbound retiming.
        dut_hash_i      = 8'h3C;
        dut_hash_ctrl_i = 2'b10;
        exp_at(K_HASH, "norm_lat1", 32'h000, 1);
        exp_at(K_HASH, "norm_3c",   32'({8'h3C, 2'b10}), 2);
        tick(3);
        dut_hash_i      = 8'hC3;
        dut_hash_ctrl_i = 2'b01;
        exp_at(K_HASH, "norm_c3", 32'({8'hC3, 2'b01}), 2);
        tick(3);

        // Loopback: data to DUT in 2 cycles, back on the bus in 4.
        loopback_ctrl_i = 2'b01;
        data_i          = 8'h5A;
        data_ctrl_i     = 3'b101;
        exp_at(K_DATA,  "lb_data_lat1", 32'h00, 1);
        exp_at(K_DATA,  "lb_data",      32'h5A, 2);
        exp_at(K_DCTRL, "lb_dctrl",     32'h5, 2);
        exp_at(K_MODE,  "lb_mode",      32'h1, 2);
        exp_at(K_HASH,  "lb_hash_5a",   32'({8'h5A, 2'b01}), 4);
        tick(6);
        data_i      = 8'h81;
        data_ctrl_i = 3'b010;
        exp_at(K_HASH, "lb_hash_81", 32'({8'h81, 2'b10}), 4);
        tick(6);

        // Pattern mode: counter from 0, wrapping past 0xFF.
        loopback_ctrl_i = 2'b10;
        for (int k = 0; k < 300; k++)
            exp_at(K_HASH, $sformatf("pat_%0d", k), 32'({8'(k), 2'b11}), 4 + k);
        tick(304);
        loopback_ctrl_i = 2'b00;
        exp_at(K_HASH, "pat_exit", 32'({8'hC3, 2'b01}), 4);
        tick(6);
        loopback_ctrl_i = 2'b10;
        for (int k = 0; k < 4; k++)
            exp_at(K_HASH, $sformatf("pat_restart_%0d", k), 32'({8'(k), 2'b11}), 4 + k);
        tick(10);

        // Fixed pattern: stable 0xA5 with zero control.
        loopback_ctrl_i = 2'b11;
        exp_at(K_MODE, "fix_mode", 32'h3, 2);
        for (int k = 0; k < 5; k++)
            exp_at(K_HASH, $sformatf("fix_%0d", k), 32'({8'hA5, 2'b00}), 4 + k);
        tick(10);
        loopback_ctrl_i = 2'b00;
        tick(4);

        // Error counting in RUN, saturating at 0xFF.
        err_i = 1'b1;
        exp_at(K_ERR,    "err_1",      32'd1, 1);
        exp_at(K_STICKY, "err_sticky", 32'h1, 1);
        exp_at(K_ERR,    "err_5",      32'd5, 5);
        exp_at(K_ERR,    "err_254",    32'd254, 254);
        exp_at(K_ERR,    "err_255",    32'd255, 255);
        exp_at(K_ERR,    "err_sat",    32'd255, 300);
        tick(300);
        err_i = 1'b0;
        tick(2);

        // Lock drop in RUN: DUT reset asserts 3 edges later, count preserved.
        pll_lock_i = 1'b0;
        exp_at(K_RSTN,  "drop_rstn_e2",  32'h1, 2);
        exp_at(K_RSTN,  "drop_rstn_e3",  32'h0, 3);
        exp_at(K_STATE, "drop_state",    32'h0, 3);
        exp_at(K_ERR,   "drop_err_kept", 32'd255, 3);
        tick(6);
        pll_lock_i = 1'b1;
        exp_at(K_RSTN, "relock_rstn_e18", 32'h0, 18);
        exp_at(K_RSTN, "relock_rstn_e19", 32'h1, 19);
        exp_at(K_ERR,  "relock_err_kept", 32'd255, 20);
        tick(22);

        // Lock lost exactly as the hold count completes: no release.
        pll_lock_i = 1'b0;
        tick(5);
        pll_lock_i = 1'b1;
        tick(16);
        pll_lock_i = 1'b0;
        exp_at(K_STATE, "race_hold15", 32'h1, 2);
        exp_at(K_STATE, "race_state",  32'h0, 3);
        exp_at(K_RSTN,  "race_rstn",   32'h0, 3);
        exp_at(K_RSTN,  "race_rstn_l", 32'h0, 8);
        tick(10);

        // Back to RUN in loopback, then an asynchronous mid-run reset.
        pll_lock_i      = 1'b1;
        tick(22);
        loopback_ctrl_i = 2'b01;
        data_i          = 8'h33;
        tick(6);
        rst_async = 1'b1;
        #1;
        check("async_err_clear",  32'(err_cnt_o), 32'h0);
        check("async_rstn_clear", 32'(dut_rst_n_o), 32'h0);
        exp_at(K_ERR,    "arst_err",    32'h00, 1);
        exp_at(K_HASH,   "arst_hash",   32'h000, 1);
        exp_at(K_DATA,   "arst_data",   32'h00, 1);
        exp_at(K_STATUS, "arst_status", 32'h00, 1);
        tick(2);
        rst_async = 1'b0;
        exp_at(K_DATA, "rec_data",     32'h33, 2);
        exp_at(K_MODE, "rec_mode",     32'h1, 2);
        exp_at(K_RSTN, "rec_rstn_e18", 32'h0, 18);
        exp_at(K_RSTN, "rec_rstn_e19", 32'h1, 19);
        tick(25);

        for (int t = 0; t < 20 && sb_q.size() != 0; t++)
            @(negedge clk);
        while (sb_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: expectation left unchecked", sb_q[0].name);
            void'(sb_q.pop_front());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
